// File: rtl/axi_lite_pkg.sv
// Shared types for the CPU-to-AXI4-Lite memory port: FSM state encoding and AXI response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_mem_port.sv
// Single-beat AXI4-Lite master that carries one MEM-stage load or store at a time,
// placing the narrow CPU word in its lane of the wider AXI data bus.
module axi_lite_mem_port
    import axi_lite_pkg::*;
#(
    parameter int                    CPU_ADDR_W     = 16,
    parameter int                    CPU_DATA_W     = 16,
    parameter int                    AXI_ADDR_W     = 32,
    parameter int                    AXI_DATA_W     = 32,
    parameter logic [AXI_ADDR_W-1:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [2:0]            AXI_PROT       = 3'b000,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic                    req_wr,
    input  logic [CPU_ADDR_W-1:0]   req_addr,
    input  logic [CPU_DATA_W-1:0]   req_wdata,
    output logic                    busy,
    output logic [CPU_DATA_W-1:0]   rdata,
    output logic                    done,
    output logic                    resp_err,
    output logic [1:0]              resp_code,
    output logic                    timeout,
    output logic [AXI_ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [AXI_DATA_W-1:0]   M_AXI_WDATA,
    output logic [AXI_DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [AXI_ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [AXI_DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int BPC    = CPU_DATA_W / 8;
    localparam int LANES  = AXI_DATA_W / CPU_DATA_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OFF_LO = $clog2(BPC);
    localparam int OFF_HI = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t                  state, state_nxt;
    logic                    aw_done, w_done;
    logic [CPU_ADDR_W-1:0]   addr_q;
    logic [CPU_DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]        cnt;
    logic [LANE_W-1:0]       lane;
    logic [CPU_DATA_W-1:0]   rd_lane;
    logic [STRB_W-1:0]       strb;
    logic [AXI_ADDR_W-1:0]   ax_sum;
    logic                    active;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    generate
        if (LANES > 1) begin : g_lane
            assign lane = addr_q[OFF_HI-1:OFF_LO];
        end else begin : g_lane_single
            assign lane = '0;
        end
    endgenerate

    always_comb begin
        rd_lane = M_AXI_RDATA[CPU_DATA_W-1:0];
        strb    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                rd_lane            = M_AXI_RDATA[i*CPU_DATA_W +: CPU_DATA_W];
                strb[i*BPC +: BPC] = '1;
            end
        end
    end

    // Address is word-aligned to the AXI bus; the lane select carries the sub-word offset.
    assign ax_sum       = ADDR_BASE + AXI_ADDR_W'(addr_q);
    assign M_AXI_AWADDR = ax_sum & ~AXI_ADDR_W'(STRB_W - 1);
    assign M_AXI_ARADDR = M_AXI_AWADDR;
    assign M_AXI_AWPROT = AXI_PROT;
    assign M_AXI_ARPROT = AXI_PROT;
    assign M_AXI_WDATA  = {LANES{wdata_q}};
    assign M_AXI_WSTRB  = strb;

    assign M_AXI_AWVALID = (state == WRITE) && !aw_done;
    assign M_AXI_WVALID  = (state == WRITE) && !w_done;
    assign M_AXI_BREADY  = (state == WRESP);
    assign M_AXI_ARVALID = (state == RADDR);
    assign M_AXI_RREADY  = (state == RDATA);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

    assign active   = (state == WRITE) || (state == WRESP) || (state == RADDR) || (state == RDATA);
    assign busy     = rst_n && (((state == IDLE) && req_valid) || active);
    assign done     = (state == DONE);
    assign resp_err = done && (resp_code != OKAY);
    assign timeout  = TO_EN && (cnt >= CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = req_wr ? WRITE : RADDR;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
            WRESP:   if (b_hs) state_nxt = DONE;
            RADDR:   if (ar_hs) state_nxt = RDATA;
            RDATA:   if (r_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cnt       <= '0;
            rdata     <= '0;
            resp_code <= OKAY;
        end else begin
            state   <= state_nxt;
            aw_done <= (state == WRITE) && (aw_done || aw_hs);
            w_done  <= (state == WRITE) && (w_done || w_hs);
            // Counter holds the number of the current stall cycle, so it starts at 1.
            if (state_nxt == DONE || state_nxt == IDLE)
                cnt <= '0;
            else if (state == IDLE)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (r_hs)
                rdata <= rd_lane;
            if (b_hs)
                resp_code <= M_AXI_BRESP;
            else if (r_hs)
                resp_code <= M_AXI_RRESP;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_port.sv
// Directed bench for axi_lite_mem_port: stores, lane-selected loads, split handshakes,
// error responses, timeout flagging and mid-transaction reset.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_axi_lite_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        busy, done, resp_err, timeout;
  logic [15:0] rdata;
  logic [1:0]  resp_code;
  logic [31:0] awaddr, araddr, wdata, rdata_in;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rdata(rdata), .done(done), .resp_err(resp_err),
    .resp_code(resp_code), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata_in), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues a load with a zero-wait slave; returns in the DONE cycle with req_valid dropped.
  task automatic read_txn(input logic [15:0] a, input logic [31:0] d, input logic [1:0] rr);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; arready = 1'b1; #1;
    `CHK("rd_busy_idle", busy, 1);
    cyc;
    `CHK("rd_arvalid", arvalid, 1);
    `CHK("rd_araddr", araddr, {16'h0, a[15:2], 2'b00});
    `CHK("rd_rready_early", rready, 0);
    cyc;
    arready = 1'b0; rvalid = 1'b1; rdata_in = d; rresp = rr; #1;
    `CHK("rd_rready", rready, 1);
    `CHK("rd_arvalid_low", arvalid, 0);
    `CHK("rd_done_early", done, 0);
    cyc;
    rvalid = 1'b0; req_valid = 1'b0; #1;
    `CHK("rd_done", done, 1);
    `CHK("rd_busy_done", busy, 0);
    `CHK("rd_rready_done", rready, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata_in = '0; rresp = 2'b00;

    // Reset state
    @(negedge clk); @(negedge clk);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_done", done, 0);
    `CHK("rst_rdata", rdata, 0);
    `CHK("rst_resp_code", resp_code, 0);
    `CHK("rst_timeout", timeout, 0);
    `CHK("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    rst_n = 1'b1;
    cyc;

    // Store 0xBEEF at 0x0012 with AW and W accepted together
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0012; req_wdata = 16'hBEEF;
    awready = 1'b1; wready = 1'b1; #1;
    `CHK("st_busy_idle", busy, 1);
    cyc;
    `CHK("st_awvalid", awvalid, 1);
    `CHK("st_wvalid", wvalid, 1);
    `CHK("st_awaddr", awaddr, 32'h0000_0010);
    `CHK("st_wdata", wdata, 32'hBEEF_BEEF);
    `CHK("st_wstrb", wstrb, 4'b1100);
    `CHK("st_awprot", awprot, 3'b000);
    cyc;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00; #1;
    `CHK("st_valids_wresp", {awvalid, wvalid}, 2'b00);
    `CHK("st_bready", bready, 1);
    `CHK("st_busy_wresp", busy, 1);
    `CHK("st_done_early", done, 0);
    cyc;
    bvalid = 1'b0; req_valid = 1'b0; #1;
    `CHK("st_done", done, 1);
    `CHK("st_resp_err", resp_err, 0);
    `CHK("st_busy_done", busy, 0);
    `CHK("st_bready_done", bready, 0);
    cyc;
    `CHK("st_done_idle", done, 0);

    // Loads select the low and high lane
    read_txn(16'h0010, 32'h1234_5678, 2'b00);
    `CHK("ld_lo_rdata", rdata, 16'h5678);
    `CHK("ld_lo_resp_err", resp_err, 0);
    cyc;
    read_txn(16'h0012, 32'h1234_5678, 2'b00);
    `CHK("ld_hi_rdata", rdata, 16'h1234);
    cyc;

    // Store with W accepted three cycles before AW, slave returns SLVERR
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0034; req_wdata = 16'h1111;
    wready = 1'b1; awready = 1'b0;
    cyc;
    `CHK("split_awaddr", awaddr, 32'h0000_0034);
    `CHK("split_wstrb", wstrb, 4'b0011);
    `CHK("split_wdata", wdata, 32'h1111_1111);
    `CHK("split_both_valid", {awvalid, wvalid}, 2'b11);
    cyc;
    wready = 1'b0; #1;
    for (int i = 2; i <= 3; i++) begin
      `CHK("split_wvalid_dropped", wvalid, 0);
      `CHK("split_awvalid_held", awvalid, 1);
      `CHK("split_awaddr_stable", awaddr, 32'h0000_0034);
      `CHK("split_no_bready", bready, 0);
      cyc;
    end
    awready = 1'b1; #1;
    `CHK("split_awvalid_c4", awvalid, 1);
    `CHK("split_wvalid_c4", wvalid, 0);
    cyc;
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b10; #1;
    `CHK("split_awvalid_low", awvalid, 0);
    `CHK("split_bready", bready, 1);
    cyc;
    bvalid = 1'b0; req_valid = 1'b0; #1;
    `CHK("split_done", done, 1);
    `CHK("split_resp_err", resp_err, 1);
    `CHK("split_resp_code", resp_code, 2'b10);
    `CHK("split_rdata_kept", rdata, 16'h1234);
    cyc;
    `CHK("split_single_wresp", {bready, done}, 2'b00);

    // Load with DECERR response
    read_txn(16'h0010, 32'hAAAA_5555, 2'b11);
    `CHK("decerr_rdata", rdata, 16'h5555);
    `CHK("decerr_resp_err", resp_err, 1);
    `CHK("decerr_resp_code", resp_code, 2'b11);
    cyc;
    `CHK("decerr_code_held", resp_code, 2'b11);
    `CHK("decerr_err_idle", resp_err, 0);

    // ARREADY held low for 10 cycles with TIMEOUT_CYCLES=4
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0012; arready = 1'b0;
    cyc;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if (timeout !== (i >= 4)) begin
        errors++;
        $error("FAIL to_flag cycle %0d observed=%0b", i, timeout);
      end
      checks++;
      if (arvalid !== 1'b1) begin
        errors++;
        $error("FAIL to_arvalid_held cycle %0d observed=%0b", i, arvalid);
      end
      cyc;
    end
    arready = 1'b1; #1;
    `CHK("to_flag_c11", timeout, 1);
    cyc;
    arready = 1'b0; rvalid = 1'b1; rdata_in = 32'h4321_0000; rresp = 2'b00; #1;
    `CHK("to_flag_rdata", timeout, 1);
    cyc;
    rvalid = 1'b0; req_valid = 1'b0; #1;
    `CHK("to_done", done, 1);
    `CHK("to_cleared", timeout, 0);
    `CHK("to_rdata", rdata, 16'h4321);
    cyc;

    // Reset asserted while waiting in WRESP
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0000; req_wdata = 16'h00FF;
    awready = 1'b1; wready = 1'b1;
    cyc;
    cyc;
    awready = 1'b0; wready = 1'b0; #1;
    `CHK("rstw_bready_pre", bready, 1);
    rst_n = 1'b0; #1;
    `CHK("rstw_bready", bready, 0);
    `CHK("rstw_busy", busy, 0);
    `CHK("rstw_done", done, 0);
    cyc;
    `CHK("rstw_done_held", done, 0);
    `CHK("rstw_rdata", rdata, 0);
    `CHK("rstw_resp_code", resp_code, 0);
    rst_n = 1'b1; req_valid = 1'b0; #1;
    cyc;
    `CHK("rstw_no_done", done, 0);
    read_txn(16'h0012, 32'h89AB_0000, 2'b00);
    `CHK("rstw_next_rdata", rdata, 16'h89AB);
    `CHK("rstw_next_err", resp_err, 0);
    cyc;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_port.md
AXI_LITE_MEM_PORT -- requirements
Module: axi_lite_mem_port

Interface
REQ-001 Parameter CPU_ADDR_W, default 16: CPU byte-address width.
REQ-002 Parameter CPU_DATA_W, default 16: CPU data width; power of two, at least 8.
REQ-003 Parameter AXI_ADDR_W, default 32: AXI address width.
REQ-004 Parameter AXI_DATA_W, default 32: AXI data width; integer multiple of CPU_DATA_W.
REQ-005 Parameter ADDR_BASE, default 32'h0000_0000: base added to every CPU address.
REQ-006 Parameter AXI_PROT, default 3'b000: value driven on AWPROT/ARPROT.
REQ-007 Parameter TIMEOUT_CYCLES, default 255: stall cycles before timeout is flagged; 0 disables.
REQ-008 Clock and reset SHALL be one clock and an asynchronous active-low reset: clk in 1, system clock; rst_n in 1, active-low async reset.
REQ-009 req_valid in 1: level request, held by the MEM stage while its LW/SW occupies it.
REQ-010 req_wr in 1: 1 = store, 0 = load.
REQ-011 req_addr in CPU_ADDR_W: CPU byte address. req_wdata in CPU_DATA_W: store data.
REQ-012 busy out 1: pipeline stall. rdata out CPU_DATA_W: load data.
REQ-013 done out 1: one-cycle completion pulse. resp_err out 1: done with non-OKAY response. resp_code out 2: last BRESP/RRESP.
REQ-014 timeout out 1: transaction exceeded TIMEOUT_CYCLES.
REQ-015 Full AXI4-Lite master channel set, M_AXI_ prefix, widths per AXI_ADDR_W/AXI_DATA_W, WSTRB AXI_DATA_W/8.

Function
REQ-016 States SHALL be IDLE, WRITE (AW+W), WRESP, RADDR, RDATA, DONE.
REQ-017 IDLE with req_valid=1 SHALL latch addr/wdata/wr and enter WRITE (wr=1) or RADDR (wr=0) next cycle.
REQ-018 busy SHALL equal (IDLE and req_valid) or state in {WRITE, WRESP, RADDR, RDATA}; busy=0 in DONE.
REQ-019 req_valid sampled in DONE SHALL be ignored; DONE always returns to IDLE after one cycle.
REQ-020 AWADDR/ARADDR SHALL be ADDR_BASE + latched addr with the low log2(AXI_DATA_W/8) bits cleared, truncated to AXI_ADDR_W.
REQ-021 Lane index SHALL be addr bits [log2(AXI_DATA_W/8)-1 : log2(CPU_DATA_W/8)].
REQ-022 WDATA SHALL replicate wdata across all lanes; WSTRB SHALL set only the selected lane's CPU_DATA_W/8 bits.
REQ-023 In WRITE, AWVALID and WVALID SHALL assert together and each SHALL drop independently after its own handshake; enter WRESP once both handshakes are done, including same-cycle completion.
REQ-024 BREADY SHALL be 1 only in WRESP; the BVALID handshake SHALL enter DONE.
REQ-025 ARVALID SHALL be 1 only in RADDR until ARREADY; RREADY SHALL be 1 only in RDATA; the RVALID handshake SHALL capture the selected lane into rdata and enter DONE.
REQ-026 rdata SHALL hold its value until the next read completes; stores SHALL not change it.
REQ-027 done SHALL be 1 exactly in DONE; resp_err = (resp_code != 2'b00) in DONE, else 0.
REQ-028 resp_code SHALL hold the last captured response until overwritten.
REQ-029 A counter SHALL count cycles in WRITE/WRESP/RADDR/RDATA, saturating; timeout SHALL assert when it reaches TIMEOUT_CYCLES (nonzero) and clear on entry to DONE.
REQ-030 A timeout SHALL NOT abort the transaction; VALID signals SHALL stay asserted until their handshake (AXI rule).
REQ-031 All AXI outputs SHALL stay stable while VALID is high and awaiting READY.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, all VALID/READY outputs 0, and busy/done/resp_err/timeout 0.
REQ-033 On reset, rdata, resp_code and the counter SHALL be 0; reset mid-transaction SHALL abandon it without a done pulse.

Structure
REQ-034 Package axi_lite_pkg SHALL hold the state enum and the response constants OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
REQ-035 The block SHALL be a single module with no sub-modules; the counter and lane mux are inline.

Verification
REQ-036 Store addr 16'h0012, data 16'hBEEF, slave AW and W ready same cycle -> AWADDR 32'h10, WDATA 32'hBEEFBEEF, WSTRB 4'b1100, done one cycle after BVALID, resp_err 0.
REQ-037 Load addr 16'h0010, RDATA 32'h1234_5678 -> rdata 16'h5678; at addr 16'h0012 -> rdata 16'h1234.
REQ-038 Store with WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID holds, single WRESP entry.
REQ-039 Load with RRESP 2'b11 -> done with resp_err 1, resp_code 2'b11.
REQ-040 TIMEOUT_CYCLES=4, ARREADY held low for 10 cycles -> timeout high from stall cycle 4, ARVALID held, timeout clears at done.
REQ-041 rst_n low during WRESP -> BREADY/busy 0 at once, no done pulse, next request runs normally.
